// File: rtl/pwm_pkg.sv
// Shared constants for the 8-channel PWM register bank and its bus masters.
package pwm_pkg;

  localparam int unsigned NUM_CH        = 8;
  localparam int unsigned E_OFF         = 0;
  localparam int unsigned D_OFF         = 4;
  localparam int unsigned T_OFF         = 8;
  localparam int unsigned CH_STRIDE     = 12;
  localparam int unsigned PERIOD_CYC_DEF = 1000000;
  localparam int unsigned DUTY_MIN_DEF  = 50000;
  localparam int unsigned DUTY_MAX_DEF  = 125000;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_WR_T    = 4'd1;
  localparam logic [3:0] ST_WR_E    = 4'd2;
  localparam logic [3:0] ST_RD_D    = 4'd3;
  localparam logic [3:0] ST_RD_WAIT = 4'd4;
  localparam logic [3:0] ST_CAPT    = 4'd5;
  localparam logic [3:0] ST_WAIT    = 4'd6;
  localparam logic [3:0] ST_WR_D    = 4'd7;
  localparam logic [3:0] ST_DONE    = 4'd8;

  function automatic logic [31:0] clamp_duty(input logic [31:0] v,
                                             input logic [31:0] lo,
                                             input logic [31:0] hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

endpackage

// File: rtl/servo_step_calc.sv
// Saturating next-duty computation: moves cur toward target by step, never past it.
module servo_step_calc (
  input  logic [31:0] cur,
  input  logic [31:0] target,
  input  logic [15:0] step,
  output logic [31:0] next_duty,
  output logic        last
);

  logic [31:0] step_ext;

  always_comb begin
    step_ext  = {16'b0, step};
    next_duty = target;
    // Compare the remaining gap against step so the add/subtract cannot wrap.
    if (step != '0) begin
      if (cur < target) begin
        if ((target - cur) > step_ext) next_duty = cur + step_ext;
      end else if (cur > target) begin
        if ((cur - target) > step_ext) next_duty = cur - step_ext;
      end
    end
    last = (next_duty == target);
  end

endmodule

// File: rtl/servo_move_sequencer.sv
// Ramps one PWM channel's duty from its live value to a commanded target in timed steps.
module servo_move_sequencer #(
  parameter int unsigned PERIOD_CYC = pwm_pkg::PERIOD_CYC_DEF,
  parameter int unsigned DUTY_MIN   = pwm_pkg::DUTY_MIN_DEF,
  parameter int unsigned DUTY_MAX   = pwm_pkg::DUTY_MAX_DEF,
  parameter int unsigned CH_STRIDE  = pwm_pkg::CH_STRIDE
) (
  input  logic        clk,
  input  logic        res,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_ch,
  input  logic [31:0] cmd_target,
  input  logic [15:0] cmd_step,
  input  logic [23:0] cmd_interval,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [31:0] cur_duty,
  output logic        bus_wr,
  output logic        bus_rd,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);
  import pwm_pkg::*;

  logic [3:0]  state;
  logic [2:0]  ch;
  logic [31:0] target;
  logic [15:0] step;
  logic [23:0] interval;
  logic [23:0] cnt;
  logic        final_wr;
  logic [31:0] base;
  logic [31:0] rd_clamped;
  logic [31:0] calc_cur;
  logic [31:0] next_duty;
  logic        next_last;
  logic        go_write, go_wait, go_done, go_abort;

  assign cmd_ready  = (state == ST_IDLE);
  assign base       = 32'(ch) * CH_STRIDE;
  assign rd_clamped = clamp_duty(bus_rdata, DUTY_MIN, DUTY_MAX);
  assign calc_cur   = (state == ST_CAPT) ? rd_clamped : cur_duty;

  servo_step_calc u_step (
    .cur       (calc_cur),
    .target    (target),
    .step      (step),
    .next_duty (next_duty),
    .last      (next_last)
  );

  // WAIT holds interval-1 cycles so consecutive duty writes land exactly interval apart.
  always_comb begin
    go_write = 1'b0;
    go_wait  = 1'b0;
    go_done  = 1'b0;
    go_abort = 1'b0;
    case (state)
      ST_CAPT: begin
        if (abort)                     go_abort = 1'b1;
        else if (rd_clamped == target) go_done  = 1'b1;
        else if (interval == 24'd1)    go_write = 1'b1;
        else                           go_wait  = 1'b1;
      end
      ST_WAIT: begin
        if (abort)               go_abort = 1'b1;
        else if (cnt == 24'd1)   go_write = 1'b1;
      end
      ST_WR_D: begin
        if (final_wr)               go_done  = 1'b1;
        else if (interval == 24'd1) go_write = 1'b1;
        else                        go_wait  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= ST_IDLE;
      ch        <= '0;
      target    <= '0;
      step      <= '0;
      interval  <= '0;
      cnt       <= '0;
      final_wr  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      cur_duty  <= '0;
      bus_wr    <= 1'b0;
      bus_rd    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      bus_wr  <= 1'b0;
      bus_rd  <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        ST_IDLE: if (cmd_valid) begin
          ch        <= cmd_ch;
          target    <= clamp_duty(cmd_target, DUTY_MIN, DUTY_MAX);
          step      <= cmd_step;
          interval  <= (cmd_interval == '0) ? 24'd1 : cmd_interval;
          busy      <= 1'b1;
          state     <= ST_WR_T;
          bus_wr    <= 1'b1;
          bus_addr  <= 32'(cmd_ch) * CH_STRIDE + T_OFF;
          bus_wdata <= PERIOD_CYC;
        end
        ST_WR_T: begin
          state     <= ST_WR_E;
          bus_wr    <= 1'b1;
          bus_addr  <= base + E_OFF;
          bus_wdata <= 32'd1;
        end
        ST_WR_E: begin
          state    <= ST_RD_D;
          bus_rd   <= 1'b1;
          bus_addr <= base + D_OFF;
        end
        ST_RD_D:    state    <= ST_RD_WAIT;
        ST_RD_WAIT: state    <= ST_CAPT;
        ST_CAPT:    cur_duty <= rd_clamped;
        ST_WAIT:    if (!go_write && !go_abort) cnt <= cnt - 24'd1;
        ST_WR_D:    ;
        ST_DONE:    state    <= ST_IDLE;
        default:    state    <= ST_IDLE;
      endcase
      if (go_write) begin
        state     <= ST_WR_D;
        bus_wr    <= 1'b1;
        bus_addr  <= base + D_OFF;
        bus_wdata <= next_duty;
        cur_duty  <= next_duty;
        final_wr  <= next_last;
      end
      if (go_wait) begin
        state <= ST_WAIT;
        cnt   <= interval - 24'd1;
      end
      if (go_done || go_abort) begin
        state   <= ST_DONE;
        done    <= 1'b1;
        aborted <= go_abort;
        busy    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_servo_move_sequencer.sv
// Scoreboard bench for servo_move_sequencer with a behavioural PWM bank and move model.
module tb_servo_move_sequencer;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_ch = '0;
  logic [31:0] cmd_target = '0;
  logic [15:0] cmd_step = '0;
  logic [23:0] cmd_interval = '0;
  logic        abort = 1'b0;
  logic        busy, done, aborted;
  logic [31:0] cur_duty;
  logic        bus_wr, bus_rd;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;

  servo_move_sequencer #(
    .PERIOD_CYC (1000000),
    .DUTY_MIN   (50000),
    .DUTY_MAX   (125000),
    .CH_STRIDE  (12)
  ) dut (
    .clk          (clk),
    .res          (res),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_ch       (cmd_ch),
    .cmd_target   (cmd_target),
    .cmd_step     (cmd_step),
    .cmd_interval (cmd_interval),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .cur_duty     (cur_duty),
    .bus_wr       (bus_wr),
    .bus_rd       (bus_rd),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 write, 1 read, 2 done
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned cyc;
    bit          flag;   // write: duty write; done: aborted
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned last_done_cyc = 0;
  logic [31:0] shadow_d[8];
  logic [31:0] mem[32];
  logic        pre_en = 1'b0;
  logic [4:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // PWM bank: registered read data, one-cycle write strobes.
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    if (bus_wr) mem[bus_addr[6:2]] <= bus_wdata;
    if (bus_rd) bus_rdata <= mem[bus_addr[6:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  function automatic ev_t mk_ev(input int kind, input logic [31:0] addr, input logic [31:0] data,
                                input int unsigned c, input bit flag);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.cyc = c; e.flag = flag;
    return e;
  endfunction

  function automatic longint clampv(input logic [31:0] v);
    longint x = longint'(v);
    if (x < 50000) return 50000;
    if (x > 125000) return 125000;
    return x;
  endfunction

  // Monitor: every strobe or done pulse consumes the oldest expected event.
  always @(negedge clk) begin : monitor
    ev_t e;
    int  kind;
    if (res) begin
      if (bus_wr && bus_rd) begin
        tests++; fails++;
        $display("FAIL wr_rd_exclusive: actual both strobes high, required at most one, cycle %0d", cyc);
      end
      if (bus_wr || bus_rd || done) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_event: actual wr=%0b rd=%0b done=%0b addr 0x%0h, required none, cycle %0d",
                   bus_wr, bus_rd, done, bus_addr, cyc);
        end else begin
          e = exp_q.pop_front();
          kind = done ? 2 : (bus_rd ? 1 : 0);
          check("event_kind", kind, e.kind);
          check("event_cycle", cyc, e.cyc);
          if (e.kind == 2) begin
            check("done_aborted", {31'b0, aborted}, {31'b0, e.flag});
            check("done_cur_duty", cur_duty, e.data);
            check("done_busy_low", {31'b0, busy}, 32'd0);
            last_done_cyc = cyc;
          end else begin
            check("bus_addr", bus_addr, e.addr);
            check("busy_high", {31'b0, busy}, 32'd1);
            if (e.kind == 0) check("bus_wdata", bus_wdata, e.data);
            if (e.kind == 0 && e.flag) check("cur_duty_follows_write", cur_duty, e.data);
          end
        end
      end
    end
  end

  // Reference model: list of duties stepping toward target, written interval apart after CAPT.
  task automatic push_move(input logic [2:0] ch, input logic [31:0] tgt_raw, input logic [15:0] st,
                           input logic [23:0] iv_raw, input int unsigned pa, input int abort_rel,
                           output int unsigned done_cyc);
    longint      cur, tgt, start, gap, fin;
    longint      dq[$];
    int unsigned iv, capt, lastw, x, n, kept;
    bit          ab;
    logic [31:0] base;
    iv    = (iv_raw == 0) ? 1 : int'(iv_raw);
    base  = 32'(ch) * 32'd12;
    tgt   = clampv(tgt_raw);
    start = clampv(shadow_d[ch]);
    cur   = start;
    exp_q.push_back(mk_ev(0, base + 8, 32'd1000000, pa, 1'b0));
    exp_q.push_back(mk_ev(0, base, 32'd1, pa + 1, 1'b0));
    exp_q.push_back(mk_ev(1, base + 4, 32'd0, pa + 2, 1'b0));
    while (cur != tgt) begin
      gap = (tgt > cur) ? tgt - cur : cur - tgt;
      if (st == 0 || gap <= longint'(st)) cur = tgt;
      else if (cur < tgt) cur = cur + longint'(st);
      else cur = cur - longint'(st);
      dq.push_back(cur);
    end
    n     = dq.size();
    capt  = pa + 4;
    lastw = capt + iv * n;
    x     = (abort_rel >= 0) ? pa + int'(abort_rel) : 0;
    ab    = (abort_rel >= 0) && ((x == capt) || (x > capt && x < lastw && ((x - capt) % iv) != 0));
    kept  = ab ? (x - capt) / iv : n;
    for (int unsigned k = 1; k <= kept; k++)
      exp_q.push_back(mk_ev(0, base + 4, 32'(dq[k-1]), capt + iv * k, 1'b1));
    fin = (kept > 0) ? dq[kept-1] : start;
    if (kept > 0) shadow_d[ch] = 32'(fin);
    done_cyc = ab ? x + 1 : lastw + 1;
    exp_q.push_back(mk_ev(2, 32'd0, 32'(fin), done_cyc, ab));
  endtask

  task automatic drive_abort(input int unsigned x);
    int w = 0;
    while (cyc < x && w < 2000) begin @(negedge clk); w++; end
    if (cyc == x) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
  endtask

  task automatic run_move(input logic [2:0] ch, input bit pre, input logic [31:0] rb,
                          input logic [31:0] tgt, input logic [15:0] st, input logic [23:0] iv,
                          input int abort_rel, input bit early, output int unsigned pa);
    int          w;
    int unsigned dc, xa;
    pa = 0;
    if (early) begin
      cmd_ch = ch; cmd_target = tgt; cmd_step = st; cmd_interval = iv; cmd_valid = 1'b1;
    end
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 1000) begin @(negedge clk); w++; end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL cmd_ready_timeout: actual 0 after %0d cycles, required 1", w);
      cmd_valid = 1'b0;
      return;
    end
    if (early) check("accept_after_done", cyc, last_done_cyc + 1);
    if (pre) begin
      pre_idx = 5'(32'(ch) * 3 + 1); pre_val = rb; pre_en = 1'b1;
      shadow_d[ch] = rb;
      @(negedge clk);
      pre_en = 1'b0;
    end
    cmd_ch = ch; cmd_target = tgt; cmd_step = st; cmd_interval = iv; cmd_valid = 1'b1;
    pa = cyc + 1;
    push_move(ch, tgt, st, iv, pa, abort_rel, dc);
    if (abort_rel >= 0) begin
      xa = pa + int'(abort_rel);
      if (xa < dc) fork drive_abort(xa); join_none
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached with %0d events pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned pa;
    logic [2:0]  rch;
    logic [31:0] rrb, rtg;
    logic [15:0] rst;
    logic [23:0] riv;
    int          rab;
    bit          rearly;
    int          w;

    for (int i = 0; i < 8; i++) shadow_d[i] = '0;

    // Reset state
    #12;
    check("rst_bus_wr", {31'b0, bus_wr}, 0);
    check("rst_bus_rd", {31'b0, bus_rd}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_cur_duty", cur_duty, 0);
    @(negedge clk);
    res = 1'b1;
    #1 check("rst_cmd_ready", {31'b0, cmd_ready}, 1);

    // Directed moves
    run_move(3'd2, 1, 32'd75000, 32'd100000, 16'd10000, 24'd4, -1, 0, pa);
    run_move(3'd7, 1, 32'd120000, 32'd10000, 16'd40000, 24'd2, -1, 0, pa);
    run_move(3'd0, 1, 32'd60000, 32'd90000, 16'd0, 24'd0, -1, 0, pa);
    run_move(3'd4, 1, 32'd70000, 32'd70000, 16'd5000, 24'd3, -1, 0, pa);
    run_move(3'd5, 1, 32'd60000, 32'd110000, 16'd10000, 24'd5, 11, 0, pa);
    run_move(3'd5, 0, 32'd0, 32'd55000, 16'd0, 24'd3, -1, 1, pa);
    run_move(3'd1, 1, 32'd50000, 32'd60000, 16'd10000, 24'd3, 7, 0, pa);
    run_move(3'd6, 1, 32'd20000, 32'd200000, 16'd30000, 24'd1, -1, 0, pa);

    // Randomized moves
    for (int i = 0; i < 24; i++) begin
      rch    = 3'($urandom_range(0, 7));
      rrb    = 32'($urandom_range(30000, 140000));
      rtg    = 32'($urandom_range(30000, 140000));
      rst    = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(6000, 40000));
      riv    = 24'($urandom_range(0, 6));
      rab    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(4, 30)) : -1;
      rearly = (i > 0) && ($urandom_range(0, 3) == 0);
      run_move(rch, !rearly, rrb, rtg, rst, riv, rab, rearly, pa);
    end

    // Reset mid-ramp, while waiting between steps
    run_move(3'd3, 1, 32'd60000, 32'd120000, 16'd10000, 24'd20, -1, 0, pa);
    w = 0;
    while (cyc < pa + 8 && w < 200) begin @(negedge clk); w++; end
    #2 res = 1'b0;
    #1;
    check("midrst_bus_wr", {31'b0, bus_wr}, 0);
    check("midrst_bus_rd", {31'b0, bus_rd}, 0);
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_done", {31'b0, done}, 0);
    check("midrst_aborted", {31'b0, aborted}, 0);
    check("midrst_bus_addr", bus_addr, 0);
    check("midrst_bus_wdata", bus_wdata, 0);
    check("midrst_cur_duty", cur_duty, 0);
    exp_q.delete();
    shadow_d[3] = 32'd60000;
    repeat (3) @(negedge clk);
    res = 1'b1;
    #1 check("midrst_cmd_ready", {31'b0, cmd_ready}, 1);
    repeat (6) @(negedge clk);
    run_move(3'd3, 0, 32'd0, 32'd80000, 16'd15000, 24'd2, -1, 0, pa);

    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin @(negedge clk); w++; end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: actual %0d events pending, required 0", exp_q.size());
    end
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
